clk_gate_ctrl: RTL and testbench
================================

CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

Interface
REQ-001 SHALL have parameter IDLE_CYCLES, default 8: consecutive idle cycles before gating; legal range 1..255.
REQ-002 SHALL have parameter WAKE_CYCLES, default 2: ungated settle cycles before ack; legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: single free-running clock for the whole block.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port req, input, 1 bit: downstream counter wants to count; held until ack.
REQ-006 SHALL have port force_on, input, 1 bit: inhibits gating while high.
REQ-007 SHALL have port ack, output, 1 bit: gated clock is running and stable; the counter may count this cycle.
REQ-008 SHALL have port gclk_en, output, 1 bit: registered clock-enable.
REQ-009 SHALL have port gclk, output, 1 bit: glitch-free gated clock feeding the downstream counter.
REQ-010 SHALL have port gate_events, output, 8 bits: number of entries into GATED, saturating.
REQ-011 SHALL have port gated_cycles, output, 16 bits: cycles spent with gclk_en=0, wrapping.

Function
REQ-012 SHALL implement FSM states RUN, HOLD, GATED and WAKE, with state, idle_cnt (8b) and wake_cnt (4b) held in registers.
REQ-013 RUN: gclk_en=1, ack=req; on req=0 and force_on=0 SHALL go to HOLD with idle_cnt=1.
REQ-014 HOLD: gclk_en=1, ack=req. On req=1 SHALL return to RUN and clear idle_cnt.
REQ-015 HOLD with req=0: when idle_cnt==IDLE_CYCLES-1 SHALL go to GATED, otherwise increment idle_cnt.
REQ-016 HOLD with IDLE_CYCLES=1: SHALL go to GATED on the first HOLD cycle.
REQ-017 force_on=1 in RUN or HOLD SHALL clear idle_cnt and go to or stay in RUN; force_on SHALL never delay WAKE.
REQ-018 GATED: gclk_en=0, ack=0. On req=1 or force_on=1 SHALL go to WAKE with wake_cnt=0.
REQ-019 WAKE: gclk_en=1, ack=0; SHALL stay exactly WAKE_CYCLES cycles, then go to RUN regardless of req.
REQ-020 req dropping during WAKE SHALL NOT abort the wake; RUN then proceeds to HOLD normally.
REQ-021 gclk_en SHALL be a flop loaded with the next-state decode (next_state != GATED), so it changes in the same cycle as state.
REQ-022 ack SHALL be combinational from registered state and req only, with no path from force_on.
REQ-023 gate_events SHALL increment on each HOLD->GATED transition and hold at 255.
REQ-024 gated_cycles SHALL increment every cycle gclk_en=0 and wrap 65535->0.
REQ-025 Simultaneous req=1 and the idle-limit cycle in HOLD SHALL resolve to RUN (req wins), and gate_events SHALL NOT increment.

Reset
REQ-026 On rst_n=0 at a clk edge the block SHALL set: state=RUN, idle_cnt=0, wake_cnt=0, gclk_en=1, gate_events=0, gated_cycles=0.
REQ-027 While rst_n=0, gclk_en SHALL be 1 so that the downstream synchronous reset sees clock edges.
REQ-028 Reset asserted mid-GATED or mid-WAKE SHALL take effect on the next clk edge; no wake sequence is required.

Structure
REQ-029 Package clk_gate_pkg SHALL hold the state enum and the widths of gate_events (8), gated_cycles (16), idle_cnt (8) and wake_cnt (4).
REQ-030 The ICG SHALL be sub-module clk_gate_icg: enable latched while clk low, gclk = clk AND latched enable, no logic on gclk beyond it.
REQ-031 All other logic SHALL be single-clock flops on clk, with no derived clocks.

Verification (IDLE_CYCLES=4, WAKE_CYCLES=2)
REQ-032 Reset then req=1 held: gclk_en=1 and ack=1 from the first post-reset cycle, and gate_events=0.
REQ-033 req drops at cycle T: HOLD for T+1..T+3, gclk_en=0 from T+4, gate_events=1, gated_cycles increments from T+4.
REQ-034 From GATED, req=1 at cycle W: gclk_en=1 at W+1, ack=0 at W+1..W+2, ack=1 at W+3.
REQ-035 force_on=1 with req=0 for 20 cycles: gclk_en stays 1 and gate_events is unchanged; force_on->0 gives GATED 4 cycles later.
REQ-036 req=1 in the same cycle that idle_cnt=3: state goes to RUN, gclk_en never drops, gate_events is unchanged.
REQ-037 300 gate/wake cycles: gate_events=255; rst_n=0 for one cycle mid-GATED: gclk_en=1 next cycle and both counters read 0.

Source files
------------

// File: rtl/clk_gate_pkg.sv
// Shared types and counter widths for the clock-gating controller.
package clk_gate_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_GATED = 2'd2,
    ST_WAKE  = 2'd3
  } state_e;

  localparam int GATE_EVT_W  = 8;
  localparam int GATED_CYC_W = 16;
  localparam int IDLE_CNT_W  = 8;
  localparam int WAKE_CNT_W  = 4;

endpackage

// File: rtl/clk_gate_icg.sv
// Latch-based integrated clock gate: enable captured while clk is low.
module clk_gate_icg (
  input  logic clk,
  input  logic en,
  output logic gclk
);

  logic en_lat;

  always_latch begin
    if (!clk) en_lat = en;
  end

  assign gclk = clk & en_lat;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Idle-detect clock-gating controller with a req/ack wake handshake and
// activity counters; drives a glitch-free gated clock for a downstream counter.
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int IDLE_CYCLES = 8,
  parameter int WAKE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req,
  input  logic                   force_on,
  output logic                   ack,
  output logic                   gclk_en,
  output logic                   gclk,
  output logic [GATE_EVT_W-1:0]  gate_events,
  output logic [GATED_CYC_W-1:0] gated_cycles
);

  localparam logic [IDLE_CNT_W-1:0] IDLE_LAST = IDLE_CNT_W'(IDLE_CYCLES - 1);
  localparam logic [WAKE_CNT_W-1:0] WAKE_LAST = WAKE_CNT_W'(WAKE_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [IDLE_CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [WAKE_CNT_W-1:0]  wake_cnt_q, wake_cnt_d;
  logic                   gclk_en_q, gclk_en_d;
  logic [GATE_EVT_W-1:0]  gate_events_q, gate_events_d;
  logic [GATED_CYC_W-1:0] gated_cycles_q, gated_cycles_d;
  logic                   gate_enter;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      idle_cnt_q     <= '0;
      wake_cnt_q     <= '0;
      gclk_en_q      <= 1'b1;
      gate_events_q  <= '0;
      gated_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      idle_cnt_q     <= idle_cnt_d;
      wake_cnt_q     <= wake_cnt_d;
      gclk_en_q      <= gclk_en_d;
      gate_events_q  <= gate_events_d;
      gated_cycles_q <= gated_cycles_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    gate_enter = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (force_on || req) begin
          idle_cnt_d = '0;
        end else begin
          state_d    = ST_HOLD;
          idle_cnt_d = IDLE_CNT_W'(1);
        end
      end
      ST_HOLD: begin
        // A request arriving on the idle-limit cycle keeps the clock running.
        if (force_on || req) begin
          state_d    = ST_RUN;
          idle_cnt_d = '0;
        end else if (idle_cnt_q >= IDLE_LAST) begin
          state_d    = ST_GATED;
          idle_cnt_d = '0;
          gate_enter = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_CNT_W'(1);
        end
      end
      ST_GATED: begin
        if (req || force_on) begin
          state_d    = ST_WAKE;
          wake_cnt_d = '0;
        end
      end
      ST_WAKE: begin
        if (wake_cnt_q >= WAKE_LAST) begin
          state_d    = ST_RUN;
          wake_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q + WAKE_CNT_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    gclk_en_d      = (state_d != ST_GATED);
    gate_events_d  = gate_events_q;
    if (gate_enter && (gate_events_q != '1)) gate_events_d = gate_events_q + GATE_EVT_W'(1);
    gated_cycles_d = gated_cycles_q;
    if (!gclk_en_q) gated_cycles_d = gated_cycles_q + GATED_CYC_W'(1);
  end

  assign ack          = req && ((state_q == ST_RUN) || (state_q == ST_HOLD));
  assign gclk_en      = gclk_en_q;
  assign gate_events  = gate_events_q;
  assign gated_cycles = gated_cycles_q;

  clk_gate_icg u_icg (
    .clk  (clk),
    .en   (gclk_en_q),
    .gclk (gclk)
  );

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Self-checking bench for clk_gate_ctrl (IDLE_CYCLES=4, WAKE_CYCLES=2).
module tb_clk_gate_ctrl;

  localparam int IDLE = 4;
  localparam int WAKE = 2;
  // Gating needs at least one HOLD cycle, so at least two idle cycles.
  localparam int GATE_AFTER = (IDLE < 2) ? 2 : IDLE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        force_on = 1'b0;
  logic        ack;
  logic        gclk_en;
  logic        gclk;
  logic [7:0]  gate_events;
  logic [15:0] gated_cycles;

  clk_gate_ctrl #(.IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .force_on     (force_on),
    .ack          (ack),
    .gclk_en      (gclk_en),
    .gclk         (gclk),
    .gate_events  (gate_events),
    .gated_cycles (gated_cycles)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Behavioural model: clock is either gated, settling (wake_left>0) or running.
  bit m_valid = 0;
  bit m_gated = 0;
  int m_wake_left = 0;
  int m_idle = 0;
  int m_events = 0;
  int m_gcyc = 0;

  logic s_en, s_ack;
  logic [7:0]  s_ev;
  logic [15:0] s_gc;

  typedef struct {
    bit r;
    bit f;
    bit en;
    bit ak;
    int ev;
    int gc;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_en();
    return !m_gated;
  endfunction

  function automatic bit m_ack(input bit r);
    return r && !m_gated && (m_wake_left == 0);
  endfunction

  task automatic model_step(input bit r, input bit f, input bit rn);
    if (!rn) begin
      m_valid = 1; m_gated = 0; m_wake_left = 0; m_idle = 0; m_events = 0; m_gcyc = 0;
    end else if (!m_valid) begin
      m_valid = 0;
    end else if (m_gated) begin
      m_gcyc = (m_gcyc + 1) % 65536;
      if (r || f) begin
        m_gated = 0;
        m_wake_left = WAKE;
      end
    end else if (m_wake_left > 0) begin
      m_wake_left--;
    end else if (r || f) begin
      m_idle = 0;
    end else begin
      m_idle++;
      if (m_idle >= GATE_AFTER) begin
        m_gated = 1;
        m_idle = 0;
        if (m_events < 255) m_events++;
      end
    end
  endtask

  // One clock cycle: apply inputs, compare outputs against the model, advance.
  task automatic cyc(input bit r, input bit f, input bit rn);
    bit cur_en;
    bit pv;
    req = r; force_on = f; rst_n = rn;
    #1;
    s_en = gclk_en; s_ack = ack; s_ev = gate_events; s_gc = gated_cycles;
    if (m_valid) begin
      chk("model_gclk_en", 32'(gclk_en), 32'(m_en()));
      chk("model_ack", 32'(ack), 32'(m_ack(r)));
      chk("model_gate_events", 32'(gate_events), m_events);
      chk("model_gated_cycles", 32'(gated_cycles), m_gcyc);
    end
    cur_en = m_en();
    pv = m_valid;
    @(posedge clk);
    model_step(r, f, rn);
    #1;
    if (pv) chk("gclk_high_phase", 32'(gclk), 32'(cur_en));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit done;
    bit rr, ff, rn;
    int saved_ev;

    tbl[0]  = '{1, 0, 1, 1, 0, 0};
    tbl[1]  = '{1, 0, 1, 1, 0, 0};
    tbl[2]  = '{0, 0, 1, 0, 0, 0};
    tbl[3]  = '{0, 0, 1, 0, 0, 0};
    tbl[4]  = '{0, 0, 1, 0, 0, 0};
    tbl[5]  = '{0, 0, 1, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 1, 0};
    tbl[7]  = '{0, 0, 0, 0, 1, 1};
    tbl[8]  = '{1, 0, 0, 0, 1, 2};
    tbl[9]  = '{1, 0, 1, 0, 1, 3};
    tbl[10] = '{1, 0, 1, 0, 1, 3};
    tbl[11] = '{1, 0, 1, 1, 1, 3};
    tbl[12] = '{0, 0, 1, 0, 1, 3};

    @(posedge clk); #1;
    cyc(0, 0, 0);
    cyc(1, 0, 0);

    // Directed gate / wake sequence from reset.
    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].r, tbl[i].f, 1);
      chk($sformatf("tbl%0d_gclk_en", i), 32'(s_en), 32'(tbl[i].en));
      chk($sformatf("tbl%0d_ack", i), 32'(s_ack), 32'(tbl[i].ak));
      chk($sformatf("tbl%0d_gate_events", i), 32'(s_ev), tbl[i].ev);
      chk($sformatf("tbl%0d_gated_cycles", i), 32'(s_gc), tbl[i].gc);
    end

    // force_on holds the clock on, then release gates four cycles later.
    saved_ev = 1;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 1);
      chk("force_gclk_en", 32'(s_en), 32'd1);
    end
    cyc(0, 0, 1);
    chk("force_gate_events", 32'(s_ev), saved_ev);
    chk("force_rel0_gclk_en", 32'(s_en), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      cyc(0, 0, 1);
      chk($sformatf("force_rel%0d_gclk_en", k), 32'(s_en), (k < 4) ? 32'd1 : 32'd0);
    end

    // Request on the idle-limit cycle wins over gating.
    cyc(1, 0, 1); cyc(1, 0, 1); cyc(1, 0, 1);
    cyc(1, 0, 1);
    chk("race_pre_ack", 32'(s_ack), 32'd1);
    saved_ev = 2;
    for (int i = 0; i < 7; i++) begin
      cyc((i >= 3) ? 1'b1 : 1'b0, 0, 1);
      chk("race_gclk_en", 32'(s_en), 32'd1);
      chk("race_gate_events", 32'(s_ev), saved_ev);
    end

    // Many gate/wake rounds to saturate gate_events.
    for (int i = 0; i < 300; i++) begin
      done = 0;
      for (int k = 0; k < 12; k++) begin
        cyc(0, 0, 1);
        if (!s_en) begin done = 1; break; end
      end
      chk("sat_gate_reached", 32'(done), 32'd1);
      done = 0;
      for (int k = 0; k < 12; k++) begin
        cyc(1, 0, 1);
        if (s_ack) begin done = 1; break; end
      end
      chk("sat_ack_reached", 32'(done), 32'd1);
    end
    chk("sat_gate_events", 32'(s_ev), 32'd255);

    // Reset in the middle of GATED.
    done = 0;
    for (int k = 0; k < 12; k++) begin
      cyc(0, 0, 1);
      if (!s_en) begin done = 1; break; end
    end
    chk("rst_gate_reached", 32'(done), 32'd1);
    cyc(0, 0, 1); cyc(0, 0, 1);
    cyc(0, 0, 0);
    cyc(0, 0, 1);
    chk("rst_gclk_en", 32'(s_en), 32'd1);
    chk("rst_gate_events", 32'(s_ev), 32'd0);
    chk("rst_gated_cycles", 32'(s_gc), 32'd0);

    // Randomised bursts against the model.
    rr = 0; ff = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 15) rr = ~rr;
      if ($urandom_range(0, 99) < 4) ff = ~ff;
      rn = ($urandom_range(0, 199) != 0);
      cyc(rr, ff, rn);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
